seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode 7-segment
// display. It steps through the digits one slot at a time. Each slot opens with a
// short all-off window so the previous digit does not ghost onto the next one.
// Leading zeros can be suppressed, and invalid BCD digits are always blanked.
// A new display word is staged in a pending buffer. It is copied into the live
// word only at the frame boundary, so a frame never shows a mix of old and new.
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lz_en,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [3:0]          bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                blank_q, blank_d;
  logic                frame_done_q, frame_done_d;

  phase_e              phase;
  logic                slot_end;
  logic                frame_end;
  logic [3:0]          cur_digit;
  logic                upper_zero;
  logic                sup;

  // Slot phase and slot/frame boundaries, decoded from the current counter position
  always_comb begin
    phase     = (cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
  end

  // Suppression: invalid BCD, or a leading zero when this digit and all above it are 0
  always_comb begin
    cur_digit  = disp_q[{idx_q, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((k >= int'(idx_q)) && (disp_q[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    sup = (cur_digit > 4'd9) || (lz_en && (idx_q != '0) && upper_zero);
  end

  // Next-state for the counters and the buffers; a load at the frame edge stays pending
  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (frame_end && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (load) begin
      pend_d   = bcd_in;
      pend_v_d = 1'b1;
    end
  end

  // Next values of the registered display outputs, taken from the pre-edge position
  always_comb begin
    bcd_out_d    = cur_digit;
    frame_done_d = frame_end;
    dig_en_d     = '0;
    blank_d      = 1'b1;
    if (phase == PH_SHOW) begin
      dig_en_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
      blank_d  = sup;
    end
  end

  // All state and output registers; reset aborts any slot and clears both buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      bcd_out_q    <= 4'd0;
      dig_en_q     <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      bcd_out_q    <= bcd_out_d;
      dig_en_q     <= dig_en_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_out    = bcd_out_q;
  assign dig_en     = dig_en_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with a small scan geometry.
// The reference model tracks elapsed time since reset and derives slot and phase
// from it arithmetically. For every clock edge it queues the expected outputs,
// and a separate monitor pops and compares them half a cycle later.
module tb_seg_scan_ctrl;

  localparam int D     = 4;
  localparam int R     = 4;
  localparam int B     = 1;
  localparam int FRAME = D * R;

  logic          clk;
  logic          rst;
  logic          load;
  logic [15:0]   bcd_in;
  logic          lz_en;
  logic [3:0]    bcd_out;
  logic [D-1:0]  dig_en;
  logic          blank;
  logic          frame_done;

  typedef struct {
    logic [3:0]   bcd;
    logic [D-1:0] en;
    logic         blk;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];

  int        checks = 0;
  int        errors = 0;

  int          m_tick;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_pv;

  seg_scan_ctrl #(
    .DIGITS      (D),
    .REFRESH_DIV (R),
    .BLANK_CYC   (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .lz_en      (lz_en),
    .bcd_out    (bcd_out),
    .dig_en     (dig_en),
    .blank      (blank),
    .frame_done (frame_done)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: predicts the outputs after the coming edge, then advances time
  task automatic modelStep(input logic r, input logic ld, input logic [15:0] b, input logic lz);
    exp_t        e;
    int          pos;
    int          slot;
    logic [3:0]  digit;
    logic [15:0] upper;
    if (r) begin
      e.bcd  = 4'd0;
      e.en   = '0;
      e.blk  = 1'b1;
      e.fd   = 1'b0;
      m_tick = 0;
      m_disp = '0;
      m_pend = '0;
      m_pv   = 1'b0;
    end else begin
      pos   = m_tick % R;
      slot  = (m_tick / R) % D;
      upper = m_disp >> (4 * slot);
      digit = upper[3:0];
      e.bcd = digit;
      e.fd  = (pos == R - 1) && (slot == D - 1);
      if (pos < B) begin
        e.en  = '0;
        e.blk = 1'b1;
      end else begin
        e.en  = D'(1 << slot);
        e.blk = (digit > 4'd9) || (lz && slot > 0 && upper == 16'd0);
      end
      if (e.fd && m_pv) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end
      if (ld) begin
        m_pend = b;
        m_pv   = 1'b1;
      end
      m_tick++;
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, queue its expectation and step past the edge
  task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] b, input logic lz);
    rst    = r;
    load   = ld;
    bcd_in = b;
    lz_en  = lz;
    modelStep(r, ld, b, lz);
    @(posedge clk);
    #1;
  endtask

  task automatic runIdle(input int n, input logic lz);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 16'($urandom), lz);
    end
  endtask

  // Idle until the next edge lands at the given position within the frame
  task automatic runToFramePos(input int target, input logic lz);
    for (int i = 0; i < FRAME; i++) begin
      if ((m_tick % FRAME) == target) break;
      applyStimulus(1'b0, 1'b0, 16'($urandom), lz);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bcd_out !== e.bcd) begin
      errors++;
      $display("[TB] FAIL bcd_out t=%0t got %h want %h", $time, bcd_out, e.bcd);
    end
    checks++;
    if (dig_en !== e.en) begin
      errors++;
      $display("[TB] FAIL dig_en t=%0t got %b want %b", $time, dig_en, e.en);
    end
    checks++;
    if (blank !== e.blk) begin
      errors++;
      $display("[TB] FAIL blank t=%0t got %b want %b", $time, blank, e.blk);
    end
    checks++;
    if (frame_done !== e.fd) begin
      errors++;
      $display("[TB] FAIL frame_done t=%0t got %b want %b", $time, frame_done, e.fd);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation on every falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    logic [15:0] mask;
    logic [15:0] rb;
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = '0;
    lz_en  = 1'b0;
    m_tick = 0;
    m_disp = '0;
    m_pend = '0;
    m_pv   = 1'b0;

    $display("[TB] reset and first frame");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'($urandom), 1'b0);
    runIdle(20, 1'b0);

    $display("[TB] load 1234, no suppression");
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    runIdle(2 * FRAME + 4, 1'b0);

    $display("[TB] leading-zero suppression");
    applyStimulus(1'b0, 1'b1, 16'h0042, 1'b1);
    runIdle(2 * FRAME + 4, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
    runIdle(2 * FRAME + 4, 1'b1);

    $display("[TB] invalid BCD digit");
    applyStimulus(1'b0, 1'b1, 16'h1A34, 1'b0);
    runIdle(2 * FRAME + 4, 1'b0);

    $display("[TB] overwrite before transfer");
    runToFramePos(3, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0);
    runIdle(2 * FRAME, 1'b0);

    $display("[TB] load on the frame edge");
    runToFramePos(5, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h3333, 1'b0);
    runToFramePos(FRAME - 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h4444, 1'b0);
    runIdle(2 * FRAME + 2, 1'b0);

    $display("[TB] reset during SHOW of digit 2");
    applyStimulus(1'b0, 1'b1, 16'h0987, 1'b1);
    runIdle(FRAME + 2, 1'b1);
    runToFramePos(2 * R + B, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h5555, 1'b1);
    runIdle(FRAME + 4, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        3:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      rb = 16'($urandom) & mask;
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0), rb,
                    1'($urandom_range(0, 1)));
    end

    rst  = 1'b0;
    load = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
